// File: rtl/regf_access_arbiter.sv
// Round-robin arbiter for three regfile masters (PEA, PEM, PEP).
// Each master has its own minimum spacing between grants, enforced by a cooldown counter.
// Grants are combinational from req/regf_rdy and registered state, and at most one is high per cycle.
//
// Ports:
//   clk, s_rst                  : clock; synchronous active-high reset
//   pea_req, pem_req, pep_req   : level requests, held until granted
//   regf_rdy                    : regfile can accept an access this cycle
//   pea_gnt, pem_gnt, pep_gnt   : one-cycle grants; a request is consumed while its grant is high
//   last_gnt_id                 : last granted master (0=PEA, 1=PEM, 2=PEP, 3=none since reset)
//   gnt_cnt                     : total grants since reset, wrapping
module regf_access_arbiter #(
  parameter int unsigned PEA_PERIOD = 2,
  parameter int unsigned PEM_PERIOD = 2,
  parameter int unsigned PEP_PERIOD = 1
) (
  input  logic        clk,
  input  logic        s_rst,
  input  logic        pea_req,
  input  logic        pem_req,
  input  logic        pep_req,
  input  logic        regf_rdy,
  output logic        pea_gnt,
  output logic        pem_gnt,
  output logic        pep_gnt,
  output logic [1:0]  last_gnt_id,
  output logic [31:0] gnt_cnt
);

  localparam int unsigned N_MASTERS  = 3;
  localparam int unsigned MAX_AM     = (PEA_PERIOD > PEM_PERIOD) ? PEA_PERIOD : PEM_PERIOD;
  localparam int unsigned MAX_PERIOD = (MAX_AM > PEP_PERIOD) ? MAX_AM : PEP_PERIOD;
  localparam int unsigned CD_W       = $clog2(MAX_PERIOD + 1);

  logic [CD_W-1:0] cd_q [N_MASTERS];
  logic [2:0]      req_vec;
  logic [2:0]      elig;
  logic [2:0]      gnt_vec;
  logic [1:0]      gnt_id;

  // Cooldown reload: grant at t makes the master eligible again at t+PERIOD.
  function automatic logic [CD_W-1:0] reload_val(input int unsigned idx);
    case (idx)
      0:       return CD_W'(PEA_PERIOD - 1);
      1:       return CD_W'(PEM_PERIOD - 1);
      default: return CD_W'(PEP_PERIOD - 1);
    endcase
  endfunction

  assign req_vec = {pep_req, pem_req, pea_req};

  // Eligibility per master.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 3; i++) begin
      elig[i] = req_vec[i] && (cd_q[i] == '0) && regf_rdy && !s_rst;
    end
  end

  // Round-robin pick starting at the master after the last one granted.
  always_comb begin
    gnt_vec = '0;
    case (last_gnt_id)
      2'd0: begin
        if      (elig[1]) gnt_vec = 3'b010;
        else if (elig[2]) gnt_vec = 3'b100;
        else if (elig[0]) gnt_vec = 3'b001;
      end
      2'd1: begin
        if      (elig[2]) gnt_vec = 3'b100;
        else if (elig[0]) gnt_vec = 3'b001;
        else if (elig[1]) gnt_vec = 3'b010;
      end
      default: begin
        if      (elig[0]) gnt_vec = 3'b001;
        else if (elig[1]) gnt_vec = 3'b010;
        else if (elig[2]) gnt_vec = 3'b100;
      end
    endcase
  end

  assign pea_gnt = gnt_vec[0];
  assign pem_gnt = gnt_vec[1];
  assign pep_gnt = gnt_vec[2];

  // Encode the one-hot grant into a master id.
  always_comb begin
    gnt_id = 2'd0;
    if (gnt_vec[1]) gnt_id = 2'd1;
    if (gnt_vec[2]) gnt_id = 2'd2;
  end

  // Cooldowns, last id and grant counter.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      for (int i = 0; i < 3; i++) cd_q[i] <= '0;
      last_gnt_id <= 2'd3;
      gnt_cnt     <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (gnt_vec[i])          cd_q[i] <= reload_val(i);
        else if (cd_q[i] != '0)  cd_q[i] <= cd_q[i] - CD_W'(1);
      end
      if (gnt_vec != '0) last_gnt_id <= gnt_id;
      // Written every cycle, so the counter always reflects the last computed sum.
      gnt_cnt <= gnt_cnt + 32'(gnt_vec != '0);
    end
  end

endmodule

// File: tb/tb_regf_access_arbiter.sv
// Bench for regf_access_arbiter: a default-parameter instance and one with
// PEA=4, PEM=5, PEP=3 share the same stimulus, and a reference model
// predicts grants, last id and counter for both.
module tb_regf_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst, pea_req, pem_req, pep_req, regf_rdy;
  logic        pea_gnt0, pem_gnt0, pep_gnt0, pea_gnt1, pem_gnt1, pep_gnt1;
  logic [1:0]  last_id0, last_id1;
  logic [31:0] cnt0, cnt1;

  regf_access_arbiter u_def (
    .clk(clk), .s_rst(s_rst), .pea_req(pea_req), .pem_req(pem_req), .pep_req(pep_req),
    .regf_rdy(regf_rdy), .pea_gnt(pea_gnt0), .pem_gnt(pem_gnt0), .pep_gnt(pep_gnt0),
    .last_gnt_id(last_id0), .gnt_cnt(cnt0)
  );

  regf_access_arbiter #(.PEA_PERIOD(4), .PEM_PERIOD(5), .PEP_PERIOD(3)) u_alt (
    .clk(clk), .s_rst(s_rst), .pea_req(pea_req), .pem_req(pem_req), .pep_req(pep_req),
    .regf_rdy(regf_rdy), .pea_gnt(pea_gnt1), .pem_gnt(pem_gnt1), .pep_gnt(pep_gnt1),
    .last_gnt_id(last_id1), .gnt_cnt(cnt1)
  );

  typedef struct {
    logic [2:0]  gnt;
    logic [1:0]  last;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q [$];
  int          per [2][3] = '{'{2, 2, 1}, '{4, 5, 3}};
  int          m_cd [2][3];
  logic [1:0]  m_last [2];
  logic [31:0] m_cnt [2];
  int          last_cyc [2][3];
  int          cyc;
  int          checks;
  int          errors;
  logic [2:0]  obs [2];
  logic [1:0]  obs_last [2];
  logic [31:0] obs_cnt [2];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Reference grant decision for instance d.
  function automatic logic [2:0] model_gnt(input int d, input logic [2:0] req,
                                           input logic rdy, input logic rst);
    logic [2:0] g;
    int start;
    int i;
    g = '0;
    if (rst || !rdy) return g;
    start = (m_last[d] == 2'd3) ? 0 : (int'(m_last[d]) + 1) % 3;
    for (int k = 0; k < 3; k++) begin
      i = (start + k) % 3;
      if (g == '0 && req[i] && m_cd[d][i] == 0) g[i] = 1'b1;
    end
    return g;
  endfunction

  // One cycle: drive at negedge, predict, compare just before posedge, advance model.
  task automatic step(input logic a, input logic m, input logic p,
                      input logic rdy, input logic rst);
    exp_t e;
    logic [2:0] mg [2];
    pea_req = a; pem_req = m; pep_req = p; regf_rdy = rdy; s_rst = rst;
    for (int d = 0; d < 2; d++) begin
      mg[d]  = model_gnt(d, {p, m, a}, rdy, rst);
      e.gnt  = mg[d];
      e.last = m_last[d];
      e.cnt  = m_cnt[d];
      sb_q.push_back(e);
    end
    #3;
    obs[0] = {pep_gnt0, pem_gnt0, pea_gnt0};
    obs[1] = {pep_gnt1, pem_gnt1, pea_gnt1};
    obs_last[0] = last_id0; obs_last[1] = last_id1;
    obs_cnt[0]  = cnt0;     obs_cnt[1]  = cnt1;
    for (int d = 0; d < 2; d++) begin
      e = sb_q.pop_front();
      check_val($sformatf("gnt[%0d]", d), 32'(obs[d]), 32'(e.gnt));
      check_val($sformatf("last_gnt_id[%0d]", d), 32'(obs_last[d]), 32'(e.last));
      check_val($sformatf("gnt_cnt[%0d]", d), obs_cnt[d], e.cnt);
      check_val($sformatf("onehot[%0d]", d), 32'($countones(obs[d]) <= 1), 32'd1);
      for (int i = 0; i < 3; i++) begin
        if (obs[d][i]) begin
          check_val($sformatf("spacing[%0d][%0d]", d, i),
                    32'((cyc - last_cyc[d][i]) >= per[d][i]), 32'd1);
          last_cyc[d][i] = cyc;
        end
        if (rst) last_cyc[d][i] = -1000;
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 3; i++) m_cd[d][i] = 0;
        m_last[d] = 2'd3;
        m_cnt[d]  = '0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (mg[d][i])            m_cd[d][i] = per[d][i] - 1;
          else if (m_cd[d][i] > 0) m_cd[d][i] = m_cd[d][i] - 1;
        end
        if (mg[d] != '0) begin
          m_last[d] = mg[d][1] ? 2'd1 : (mg[d][2] ? 2'd2 : 2'd0);
          m_cnt[d]  = m_cnt[d] + 32'd1;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  logic [2:0] seq028 [6];

  initial begin
    checks = 0; errors = 0; cyc = 0;
    s_rst = 1'b1; pea_req = 1'b0; pem_req = 1'b0; pep_req = 1'b0; regf_rdy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        m_cd[d][i] = 0;
        last_cyc[d][i] = -1000;
      end
      m_last[d] = 2'd3;
      m_cnt[d]  = '0;
    end
    @(negedge clk);

    // Reset with all requests high: no grants, reset values.
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    check_val("rst_last", 32'(obs_last[0]), 32'd3);
    check_val("rst_cnt", obs_cnt[0], 32'd0);

    // Only PEP held 4 cycles: granted every cycle on the default instance.
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 1, 0);
      check_val("pep_b2b", 32'(obs[0]), 32'b100);
    end
    step(0, 0, 0, 1, 0);
    check_val("pep_cnt", obs_cnt[0], 32'd4);
    check_val("pep_last", 32'(obs_last[0]), 32'd2);

    // All requests from reset release: strict rotation.
    step(0, 0, 0, 1, 1);
    seq028 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 1, 1, 0);
      check_val("rr_seq", 32'(obs[0]), 32'(seq028[k]));
    end

    // regf_rdy low for three cycles blocks everything.
    step(0, 0, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 1, (k == 3), 0);
      check_val("rdy_gate", 32'(obs[0]), (k == 3) ? 32'b001 : 32'b000);
    end
    step(1, 1, 1, 1, 0);
    check_val("rdy_cnt", obs_cnt[0], 32'd1);

    // PEA period 4: grants at 0, 4, 8 only.
    step(0, 0, 0, 1, 1);
    for (int k = 0; k < 9; k++) begin
      step(1, 0, 0, 1, 0);
      check_val("pea_p4", 32'(obs[1]), (k % 4 == 0) ? 32'b001 : 32'b000);
    end

    // Reset mid-cooldown discards it.
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 1, 0);
    check_val("pem_t", 32'(obs[1]), 32'b010);
    step(0, 1, 0, 1, 1);
    check_val("pem_rst", 32'(obs[1]), 32'b000);
    step(0, 1, 0, 1, 0);
    check_val("pem_after_rst", 32'(obs[1]), 32'b010);
    check_val("pem_after_last", 32'(obs_last[1]), 32'd3);
    check_val("pem_after_cnt", obs_cnt[1], 32'd0);

    // Counter wrap.
    step(0, 0, 0, 1, 0);
    force u_def.gnt_cnt = 32'hFFFF_FFFF;
    force u_alt.gnt_cnt = 32'hFFFF_FFFF;
    m_cnt[0] = 32'hFFFF_FFFF;
    m_cnt[1] = 32'hFFFF_FFFF;
    step(0, 0, 0, 1, 0);
    release u_def.gnt_cnt;
    release u_alt.gnt_cnt;
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check_val("cnt_wrap", obs_cnt[0], 32'd0);

    // Random traffic, including requests dropped and re-raised in cooldown.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regf_access_arbiter.md
REGF_ACCESS_ARBITER -- requirements
Module: regf_access_arbiter

Interface
REQ-001 SHALL have parameter PEA_PERIOD, default 2, min cycles between two PEA grants (>=1).
REQ-002 SHALL have parameter PEM_PERIOD, default 2, min cycles between two PEM grants (>=1).
REQ-003 SHALL have parameter PEP_PERIOD, default 1, min cycles between two PEP grants (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port s_rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have ports pea_req, pem_req, pep_req  input  1 each  regfile access request; level, held until granted.
REQ-007 SHALL have ports pea_gnt, pem_gnt, pep_gnt  output  1 each  one-cycle grant; a request is consumed in the cycle its grant is high.
REQ-008 SHALL have port regf_rdy  input  1  regfile able to accept an access this cycle.
REQ-009 SHALL have port last_gnt_id  output  2  last granted master: 0=PEA, 1=PEM, 2=PEP, 3=none since reset.
REQ-010 SHALL have port gnt_cnt  output  32  total grants since reset.

Function
REQ-011 SHALL keep one cooldown counter per master, width clog2(max period + 1).
REQ-012 SHALL mark a master eligible when its req is high, its cooldown is 0, regf_rdy is high and s_rst is low.
REQ-013 SHALL drive grants combinationally from req/regf_rdy and registered state (0-cycle latency), at most one grant high per cycle.
REQ-014 SHALL, when several masters are eligible, grant round-robin: search order starts at the master after last_gnt_id (PEA->PEM->PEP->PEA); with last_gnt_id=3, order starts at PEA.
REQ-015 SHALL, on a grant, load the granted master's cooldown with PERIOD-1 at the next edge.
REQ-016 SHALL decrement every non-zero cooldown by 1 per cycle, saturating at 0, regardless of req/regf_rdy.
REQ-017 SHALL, with PERIOD=1, allow back-to-back grants to the same master when it is the only eligible one.
REQ-018 SHALL, with PERIOD=P, produce grants of one master no closer than P cycles apart (grant at t, earliest next at t+P).
REQ-019 SHALL issue no grant in any cycle with regf_rdy low; cooldowns still decrement.
REQ-020 SHALL update last_gnt_id to the granted master's id at the edge following a grant; otherwise hold.
REQ-021 SHALL increment gnt_cnt by 1 at the edge following each grant, wrapping 0xFFFFFFFF -> 0.
REQ-022 SHALL never grant a master whose req is low, including a req dropped while the master is in cooldown.
REQ-023 SHALL treat a req that falls and rises again in cooldown identically to a held req (no state per request).

Reset
REQ-024 SHALL, while s_rst is high, hold all grants at 0 regardless of inputs.
REQ-025 SHALL, at an edge with s_rst high, clear all cooldowns to 0, set last_gnt_id to 3 and gnt_cnt to 0.
REQ-026 SHALL, on reset asserted mid-cooldown, discard the cooldown; the first cycle after reset release may grant any eligible master.

Verification
REQ-027 SHALL cover: defaults, only pep_req=1 held 4 cycles, regf_rdy=1 -> pep_gnt=1 on all 4 cycles, gnt_cnt=4, last_gnt_id=2.
REQ-028 SHALL cover: defaults, pea_req=pem_req=pep_req=1 held from reset release -> grant sequence PEA, PEM, PEP, PEA, PEM, PEP; no master granted twice within 2 cycles.
REQ-029 SHALL cover: PEA_PERIOD=4, only pea_req=1 held 9 cycles -> pea_gnt at cycles 0, 4, 8 only.
REQ-030 SHALL cover: all reqs=1, regf_rdy=0 for cycles 0-2, then 1 -> no grant in cycles 0-2, PEA granted at cycle 3, gnt_cnt=1 at cycle 4.
REQ-031 SHALL cover: PEM_PERIOD=5, PEM granted at t, s_rst=1 at t+1, released at t+2 with pem_req=1 -> pem_gnt=1 at t+2, last_gnt_id=3 at t+2, gnt_cnt=0 at t+2.
REQ-032 SHALL cover: gnt_cnt forced near wrap (0xFFFFFFFF), one grant -> gnt_cnt=0 next cycle; random req/regf_rdy run checking one-hot grants and per-master spacing >= PERIOD.
